sigmoid_pwl_seq: RTL and testbench
==================================

// Module: sigmoid_pwl_seq
// PURPOSE
//  Sequencer for the piecewise-linear sigmoid approximation (PLAN segments).
//  Accepts one signed fixed-point sample per transaction, forms |x|, picks the segment, evaluates
//  slope*|x| + offset with shifts, then mirrors negative inputs as 1 - y.
//  Sits between the VAE activation stream and the latent/decoder layers; one sample in flight.
// PARAMETERS
//  W     16  data width, two's complement, signed in / unsigned-valued out
//  FRAC  12  fractional bits; legal 5..12 (1.0 = 1<<FRAC)
// PORTS
//  clk        in   1  rising-edge clock
//  rst_n      in   1  asynchronous active-low reset
//  in_valid   in   1  sample x_in valid
//  in_ready   out  1  block can accept a sample (high only in IDLE)
//  x_in       in   W  input x, signed Q(W-1-FRAC).FRAC
//  out_valid  out  1  y_out valid; held until out_ready
//  out_ready  in   1  downstream accepts y_out
//  y_out      out  W  sigmoid(x), Q.FRAC, range 0..(1<<FRAC)
//  seg_out    out  2  segment used: 0 |x|<1, 1 1<=|x|<2.375, 2 2.375<=|x|<5, 3 |x|>=5
//  busy       out  1  high whenever state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=1; out_valid=0; y_out=0; seg_out=0; busy=0; all internal regs 0.
//  FSM: IDLE -> ABS -> SEG -> EVAL -> MIRR -> OUT -> IDLE.
//   IDLE: on in_valid&&in_ready, latch x_in and sign bit; -> ABS.
//   ABS : a = sign ? -x : x; x = -2^(W-1) saturates to 2^(W-1)-1.
//   SEG : compare a against ONE=1<<FRAC, B1=19<<(FRAC-3), B2=5<<FRAC (unsigned); set seg.
//   EVAL: seg0 y=(a>>2)+(1<<(FRAC-1)); seg1 y=(a>>3)+(5<<(FRAC-3));
//         seg2 y=(a>>5)+(27<<(FRAC-5)); seg3 y=ONE. Shifts are logical (a is non-negative).
//   MIRR: if sign, y = ONE + ~y + 1 (i.e. ONE - y); else y unchanged. Result never negative.
//   OUT : out_valid=1, y_out/seg_out stable; on out_ready -> IDLE, out_valid=0 same edge.
//  Latency: accept edge to out_valid high = 5 clocks; throughput 1 sample / 6 clocks min.
//  Backpressure: stays in OUT indefinitely while out_ready=0; in_ready stays 0.
//  in_valid outside IDLE is ignored (not latched); x_in only sampled on the accept edge.
//  x=0 is treated as positive (seg0, y=ONE/2).
//  Boundaries use >=: |x|==ONE -> seg1; |x|==B1 -> seg2; |x|==B2 -> seg3.
//  Arithmetic in W bits unsigned; no overflow possible for legal FRAC (max y = ONE).
//  y_out/seg_out hold last result after out handshake until next OUT entry.
//  Async reset mid-transaction: sample discarded, all outputs to reset values immediately.
// TESTING (W=16, FRAC=12)
//  x=0 -> after 5 clk out_valid=1, y_out=2048, seg_out=0; in_ready low cycles 1..6.
//  x=4096 -> y_out=3072, seg 1; x=-4096 -> y_out=1024, seg 1 (mirror).
//  x=12288 -> y_out=3840, seg 2; x=20480 -> y_out=4096, seg 3; x=20479 -> 4095, seg 2.
//  x=-32768 -> abs saturates, seg 3, y_out=0; x=32767 -> y_out=4096.
//  out_ready held 0 for 10 clk in OUT -> out_valid/y_out stable, in_valid pulses ignored,
//   then out_ready=1 -> idle next clk, next sample accepted.
//  rst_n low during EVAL -> out_valid=0, busy=0, in_ready=1 asynchronously; next sample correct.

Source files
------------

// File: rtl/sigmoid_pwl_seq.sv
// -----------------------------------------------------------------------------
// sigmoid_pwl_seq
//   Multi-cycle sequencer for the PLAN piecewise-linear sigmoid approximation.
//   Takes one signed fixed-point sample at a time. It forms |x| and picks one of
//   four segments. It evaluates slope*|x| + offset using only shifts and adds.
//   For negative inputs it mirrors the result as 1 - y. Only one sample is in
//   flight at a time.
//
// Parameters
//   W     data width (two's complement in, unsigned-valued out)
//   FRAC  fractional bits, legal 5..12 (1.0 = 1 << FRAC)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   x_in valid
//   in_ready   sample can be accepted (IDLE only)
//   x_in       signed Q(W-1-FRAC).FRAC input
//   out_valid  y_out/seg_out valid, held until out_ready
//   out_ready  downstream accepts the result
//   y_out      sigmoid(x) in Q.FRAC, range 0..(1 << FRAC)
//   seg_out    segment used: 0 |x|<1, 1 <2.375, 2 <5, 3 >=5
//   busy       high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module sigmoid_pwl_seq #(
  parameter int W    = 16,
  parameter int FRAC = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] x_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] y_out,
  output logic [1:0]   seg_out,
  output logic         busy
);

  localparam logic [W-1:0] C_ONE  = W'(1)  << FRAC;
  localparam logic [W-1:0] C_B1   = W'(19) << (FRAC - 3);   // 2.375
  localparam logic [W-1:0] C_B2   = W'(5)  << FRAC;         // 5.0
  localparam logic [W-1:0] C_OFF0 = W'(1)  << (FRAC - 1);   // 0.5
  localparam logic [W-1:0] C_OFF1 = W'(5)  << (FRAC - 3);   // 0.625
  localparam logic [W-1:0] C_OFF2 = W'(27) << (FRAC - 5);   // 0.84375
  localparam logic [W-1:0] C_MIN  = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] C_MAX  = {1'b0, {(W-1){1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE, S_ABS, S_SEG, S_EVAL, S_MIRR, S_OUT
  } state_t;

  state_t       r_state, w_next;
  logic [W-1:0] r_x, r_a, r_y, r_y_out;
  logic         r_sign;
  logic [1:0]   r_seg, r_seg_out;

  logic [W-1:0] w_abs, w_eval, w_mirr;
  logic [1:0]   w_seg;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default first so that no path
  // through the case leaves it unassigned and infers a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_next = S_ABS;
      S_ABS:   w_next = S_SEG;
      S_SEG:   w_next = S_EVAL;
      S_EVAL:  w_next = S_MIRR;
      S_MIRR:  w_next = S_OUT;
      S_OUT:   if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath combinational steps, one per sequencer state
  // ---------------------------------------------------------------------------
  // The most negative input has no positive counterpart, so it clamps to the max.
  always_comb begin
    w_abs = r_x;
    if (r_sign) w_abs = (r_x == C_MIN) ? C_MAX : (W'(0) - r_x);
  end

  always_comb begin
    w_seg = 2'd0;
    if      (r_a >= C_B2)  w_seg = 2'd3;
    else if (r_a >= C_B1)  w_seg = 2'd2;
    else if (r_a >= C_ONE) w_seg = 2'd1;
  end

  // r_a is non-negative, so logical shifts are exact slope multiplies.
  always_comb begin
    w_eval = C_ONE;
    case (r_seg)
      2'd0:    w_eval = (r_a >> 2) + C_OFF0;
      2'd1:    w_eval = (r_a >> 3) + C_OFF1;
      2'd2:    w_eval = (r_a >> 5) + C_OFF2;
      default: w_eval = C_ONE;
    endcase
  end

  // y never exceeds ONE, so the mirrored value cannot go negative.
  assign w_mirr = r_sign ? (C_ONE - r_y) : r_y;

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so that every register
  // samples the values from before the edge, whatever the statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x       <= '0;
      r_sign    <= 1'b0;
      r_a       <= '0;
      r_seg     <= 2'd0;
      r_y       <= '0;
      r_y_out   <= '0;
      r_seg_out <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_x    <= x_in;
          r_sign <= x_in[W-1];
        end
        S_ABS:  r_a <= w_abs;
        S_SEG:  r_seg <= w_seg;
        S_EVAL: r_y <= w_eval;
        // The output registers load only on entry to OUT. They keep the last
        // result visible after the handshake until the next one replaces it.
        S_MIRR: begin
          r_y_out   <= w_mirr;
          r_seg_out <= r_seg;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = (r_state == S_OUT);
  assign y_out     = r_y_out;
  assign seg_out   = r_seg_out;

endmodule

// File: tb/tb_sigmoid_pwl_seq.sv
// -----------------------------------------------------------------------------
// tb_sigmoid_pwl_seq
//   Directed bench for sigmoid_pwl_seq (W=16, FRAC=12). A behavioural model
//   computes the expected sigmoid value for every accepted sample and pushes it
//   into a queue. One compare process checks y_out/seg_out on every cycle that
//   out_valid is high. The directed tasks also check hand-computed literals,
//   timing, backpressure and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_sigmoid_pwl_seq;

  localparam int W    = 16;
  localparam int FRAC = 12;
  localparam int ONE  = 1 << FRAC;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y_out;
  logic [1:0]   seg_out;
  logic         busy;

  int n_pass  = 0;
  int n_total = 0;
  int exp_y_q[$];
  int exp_s_q[$];

  sigmoid_pwl_seq #(.W(W), .FRAC(FRAC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y_out     (y_out),
    .seg_out   (seg_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Sigmoid approximation from its real-valued definition, scaled to FRAC bits:
  //   |x|<1: 0.25|x|+0.5, |x|<2.375: 0.125|x|+0.625, |x|<5: |x|/32+0.84375, else 1.
  function automatic void model(input int x, output int y, output int seg);
    int a;
    a = (x < 0) ? -x : x;
    if (a > (1 << (W - 1)) - 1) a = (1 << (W - 1)) - 1;
    if (a < ONE) begin
      seg = 0; y = a / 4 + ONE / 2;
    end else if (a * 8 < 19 * ONE) begin
      seg = 1; y = a / 8 + (5 * ONE) / 8;
    end else if (a < 5 * ONE) begin
      seg = 2; y = a / 32 + (27 * ONE) / 32;
    end else begin
      seg = 3; y = ONE;
    end
    if (x < 0) y = ONE - y;
  endfunction

  // Compare process: while out_valid is high, every cycle must show the oldest
  // expected result. The entry is retired on the handshake edge.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_y_q.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        check("cmp_y_out", int'(y_out), exp_y_q[0]);
        check("cmp_seg_out", int'(seg_out), exp_s_q[0]);
        if (out_ready) begin
          void'(exp_y_q.pop_front());
          void'(exp_s_q.pop_front());
        end
      end
    end
  end

  // Present x and hold in_valid until the accept edge. After that, scramble x_in
  // so that any sampling beyond the accept edge would be visible.
  task automatic send(input int x);
    bit got;
    int my, ms;
    in_valid = 1'b1;
    x_in     = 16'(x);
    got      = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
    end
    if (!got) begin
      check("accept_timeout", 0, 1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      model(x, my, ms);
      exp_y_q.push_back(my);
      exp_s_q.push_back(ms);
      #1;
      in_valid = 1'b0;
      x_in     = 16'($urandom);
    end
  endtask

  // One full transaction with out_ready already high. It checks the latency,
  // in_ready/busy while in flight, the literal result, the model against that
  // literal, and the hold of the result after the handshake.
  task automatic run(input string name, input int x, input int ey, input int es);
    int lat, bad, my, ms;
    model(x, my, ms);
    check({name, "_model_y"}, my, ey);
    check({name, "_model_seg"}, ms, es);
    send(x);
    lat = 0;
    bad = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clk);
      if (in_ready || !busy) bad++;
      if (out_valid) lat = k;
    end
    check({name, "_latency"}, lat, 5);
    check({name, "_busy_window"}, bad, 0);
    check({name, "_y_out"}, int'(y_out), ey);
    check({name, "_seg_out"}, int'(seg_out), es);
    @(negedge clk);
    check({name, "_back_idle"}, {30'd0, in_ready, out_valid}, 2);
    check({name, "_y_hold"}, int'(y_out), ey);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, lat;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    x_in      = '0;
    #12;
    check("reset_in_ready", int'(in_ready), 1);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_y_out", int'(y_out), 0);
    check("reset_seg_out", int'(seg_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors with hand-computed results.
    run("x0",       0,      2048, 0);
    run("x4096",    4096,   3072, 1);
    run("xm4096",  -4096,   1024, 1);
    run("x4095",    4095,   3071, 0);
    run("x9727",    9727,   3775, 1);
    run("x9728",    9728,   3760, 2);
    run("x12288",   12288,  3840, 2);
    run("x20479",   20479,  4095, 2);
    run("x20480",   20480,  4096, 3);
    run("xm20480", -20480,  0,    3);
    run("xm32768", -32768,  0,    3);
    run("x32767",   32767,  4096, 3);

    // Backpressure: result held for 10 cycles while in_valid pulses are ignored.
    out_ready = 1'b0;
    send(12288);
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clk);
      if (out_valid) lat = k;
    end
    check("bp_latency", lat, 5);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      in_valid = i[0];
      x_in     = 16'($urandom);
      @(negedge clk);
      if (!out_valid || in_ready || int'(y_out) != 3840 || int'(seg_out) != 2) bad++;
    end
    check("bp_stable", bad, 0);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_still_out", int'(out_valid), 1);
    @(negedge clk);
    check("bp_idle_in_ready", int'(in_ready), 1);
    check("bp_idle_out_valid", int'(out_valid), 0);
    check("bp_queue_drained", exp_y_q.size(), 0);
    @(posedge clk);
    #1;
    run("after_bp", 20479, 4095, 2);

    // Asynchronous reset while the sample is in EVAL.
    send(4096);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_y_q.delete();
    exp_s_q.delete();
    check("arst_out_valid", int'(out_valid), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_in_ready", int'(in_ready), 1);
    check("arst_y_out", int'(y_out), 0);
    check("arst_seg_out", int'(seg_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run("after_rst", -4096, 1024, 1);

    check("final_queue_empty", exp_y_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
